// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: bird physics, IDLE/PLAYING/DEAD sequencing and BCD score.
// Ports: clk, reset (async high), start_button, flap_button, hCount, vCount,
//   bright, bird_opaque, pipe_pixel, pipe_pass -> bird_y, pipe_run_en,
//   pipe_reset, state, score.
module flappy_game_ctrl #(
    parameter int BIRD_Y0  = 220,
    parameter int Y_MIN    = 35,
    parameter int Y_MAX    = 498,
    parameter int V_TICK   = 515,
    parameter int GRAVITY  = 1,
    parameter int FLAP_V   = 6,
    parameter int MAX_FALL = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_button,
    input  logic        flap_button,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic        bird_opaque,
    input  logic        pipe_pixel,
    input  logic        pipe_pass,
    output logic [9:0]  bird_y,
    output logic        pipe_run_en,
    output logic        pipe_reset,
    output logic [1:0]  state,
    output logic [15:0] score
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAYING = 2'b01,
        DEAD    = 2'b10
    } state_t;

    localparam logic signed [7:0]  MAXF_S  = 8'(MAX_FALL);
    localparam logic signed [7:0]  FLAPV_S = 8'(-FLAP_V);
    localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);
    localparam logic signed [10:0] YMIN_S  = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S  = 11'(Y_MAX);

    state_t             state_q, state_d;
    logic [9:0]         bird_y_q, bird_y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [15:0]        score_q, score_d;
    logic               flap_q, flap_d;
    logic               hit_q, hit_d;
    logic               prst_q, prst_d;
    logic               tick_q;
    // [0]/[1] synchronizer, [2] previous synchronized level
    logic [2:0]         start_sync_q, flap_sync_q;
    logic               start_edge_q, flap_edge_q;

    logic signed [7:0]  vel_sum, vel_new;
    logic signed [10:0] y_next;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign vel_sum = vel_q + GRAV_S;
    assign vel_new = flap_q ? FLAPV_S :
                     (vel_sum > MAXF_S) ? MAXF_S : vel_sum;
    assign y_next  = $signed({1'b0, bird_y_q}) +
                     $signed({{3{vel_new[7]}}, vel_new});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync_q <= '0;
            flap_sync_q  <= '0;
            start_edge_q <= 1'b0;
            flap_edge_q  <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_button};
            flap_sync_q  <= {flap_sync_q[1:0], flap_button};
            start_edge_q <= start_sync_q[1] & ~start_sync_q[2];
            flap_edge_q  <= flap_sync_q[1] & ~flap_sync_q[2];
            tick_q       <= (hCount == 10'd0) && (vCount == 10'(V_TICK));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bird_y_q <= 10'(BIRD_Y0);
            vel_q    <= '0;
            score_q  <= '0;
            flap_q   <= 1'b0;
            hit_q    <= 1'b0;
            prst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bird_y_q <= bird_y_d;
            vel_q    <= vel_d;
            score_q  <= score_d;
            flap_q   <= flap_d;
            hit_q    <= hit_d;
            prst_q   <= prst_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bird_y_d = bird_y_q;
        vel_d    = vel_q;
        score_d  = score_q;
        flap_d   = flap_q;
        hit_d    = hit_q;
        prst_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bird_y_d = 10'(BIRD_Y0);
                vel_d    = '0;
                score_d  = '0;
                flap_d   = 1'b0;
                hit_d    = 1'b0;
                if (start_edge_q) state_d = PLAYING;
            end
            PLAYING: begin
                if (pipe_pass) score_d = bcd_inc(score_q);
                // Clear first so a latch in the tick cycle carries forward
                if (tick_q) begin
                    flap_d = 1'b0;
                    hit_d  = 1'b0;
                end
                if (flap_edge_q) flap_d = 1'b1;
                if (bright && bird_opaque && pipe_pixel) hit_d = 1'b1;
                if (tick_q) begin
                    if (hit_q) begin
                        state_d = DEAD;
                    end else if (y_next <= YMIN_S) begin
                        bird_y_d = 10'(Y_MIN);
                        vel_d    = '0;
                    end else if (y_next >= YMAX_S) begin
                        bird_y_d = 10'(Y_MAX);
                        vel_d    = vel_new;
                        state_d  = DEAD;
                    end else begin
                        bird_y_d = y_next[9:0];
                        vel_d    = vel_new;
                    end
                end
            end
            DEAD: begin
                flap_d = 1'b0;
                hit_d  = 1'b0;
                if (start_edge_q) begin
                    state_d = IDLE;
                    prst_d  = 1'b1;
                    score_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bird_y      = bird_y_q;
    assign pipe_run_en = (state_q == PLAYING);
    assign pipe_reset  = prst_q;
    assign state       = state_q;
    assign score       = score_q;

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-state controller for the Flappy Bird VGA datapath. It owns the bird's vertical position and velocity, the IDLE/PLAYING/DEAD sequencing and the BCD score. It gates and resets the pipe renderer. It sits beside the pixel-priority mux: it consumes the per-pixel bird-opacity and pipe-hit signals and the VGA counters, and it drives `bird_y`, `pipe_run_en`, `pipe_reset` and `score`.

## Interface
- `BIRD_Y0`, 220: bird top row on entry to IDLE.
- `Y_MIN`, 35: ceiling row (first visible line).
- `Y_MAX`, 498: ground limit for bird top row (last visible line 514 minus sprite height 16).
- `V_TICK`, 515: vCount value that generates the frame tick (first blank line).
- `GRAVITY`, 1: per-frame velocity increment, in px/frame.
- `FLAP_V`, 6: upward velocity magnitude set by a flap.
- `MAX_FALL`, 8: terminal downward velocity.

- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start_button`  in  1  raw button, asynchronous.
- `flap_button`  in  1  raw button, asynchronous.
- `hCount`, `vCount`  in  10 each  VGA counters.
- `bright`  in  1  visible-region flag.
- `bird_opaque`  in  1  current pixel is a non-transparent bird sprite pixel.
- `pipe_pixel`  in  1  current pixel is a pipe pixel.
- `pipe_pass`  in  1  one-cycle pulse when a pipe clears the bird column.
- `bird_y`  out  10  bird top row.
- `pipe_run_en`  out  1  pipe scroll enable.
- `pipe_reset`  out  1  one-cycle pipe renderer reset pulse.
- `state`  out  2  00 IDLE, 01 PLAYING, 10 DEAD.
- `score`  out  16  4-digit packed BCD.

## Operation
- Input conditioning
  - Each button passes through a 2-flop synchronizer plus a rising-edge detector, giving `start_edge` and `flap_edge`.
  - Holding a button produces exactly one edge.
- Frame tick
  - `tick` is asserted for one cycle when `hCount==0 && vCount==V_TICK`, and is registered.
  - All physics updates happen only on `tick`.
- Flap latching: `flap_edge` sets `flap_pend`. `flap_pend` is cleared on `tick`. Multiple flaps within one frame count as one.
- Collision latching
  - In PLAYING, `bright && bird_opaque && pipe_pixel` sets `hit`.
  - `hit` is cleared on `tick`, after being sampled.
- States
  - IDLE
    - `bird_y=BIRD_Y0`, velocity 0, `score` held at 0, `pipe_run_en=0`.
    - `start_edge` moves to PLAYING and asserts `pipe_run_en` from the next cycle.
  - PLAYING, on each `tick`, in priority order:
    1. If `hit`: move to DEAD; `bird_y` and velocity hold.
    2. Otherwise update velocity: `vel = flap_pend ? -FLAP_V : min(vel+GRAVITY, MAX_FALL)`.
    3. Compute `y_next = bird_y + vel` in 11-bit signed arithmetic.
    4. If `y_next <= Y_MIN`: `bird_y=Y_MIN`, `vel=0`.
    5. Else if `y_next >= Y_MAX`: `bird_y=Y_MAX` and move to DEAD.
    6. Else `bird_y=y_next`.
  - DEAD
    - `pipe_run_en=0`; `bird_y` and `score` frozen; flaps ignored.
    - `start_edge` moves to IDLE and pulses `pipe_reset` for one cycle.
    - `score` clears to 0 on IDLE entry.
- Velocity: 8-bit two's complement.
- Score
  - `pipe_pass` in PLAYING increments the BCD value with a per-digit carry 9 to 0.
  - Saturates at 0x9999.
  - `pipe_pass` is ignored in IDLE and DEAD.
  - `pipe_pass` in the same cycle as the DEAD transition still counts, because the state is still PLAYING in that cycle.
- `start_edge` in PLAYING is ignored.

## Timing
- Reset values:
  - `state=IDLE`, `bird_y=BIRD_Y0`, vel 0.
  - `score=0`, `pipe_run_en=0`, `pipe_reset=0`.
  - `flap_pend=0`, `hit=0`, synchronizers 0.
- Button to edge: 2–3 cycles of synchronizer latency, then the edge is registered.
- State change to outputs: `state` and `pipe_run_en` update 1 cycle after the triggering edge or `tick`.
- `bird_y` update: 1 cycle after `tick`. It is stable for the whole next visible frame.
- `score`: updates 1 cycle after `pipe_pass`.
- `reset` mid-game forces every register to its reset value immediately and asynchronously.

## Test plan
- **Reset:** assert `reset` mid-PLAYING with `score=0x0042`.
  - Required: immediately `state=00`, `bird_y=220`, `score=0`, `pipe_run_en=0`.
- **Free fall:** start, then 3 ticks with no flap.
  - Required: vel 1, 2, 3; `bird_y=221, 223, 226`.
- **Flap:** one flap pressed before a tick at `bird_y=226`.
  - Required: vel −6, `bird_y=220`.
  - Two flaps in the same frame give the same result.
- **Ground death:** let the bird fall to `y_next>=498`.
  - Required: `bird_y=498`, `state=10`, `pipe_run_en=0`.
  - Next start press: `state=00`, one-cycle `pipe_reset`, `score=0`.
- **Collision:**
  - Assert `bright`, `bird_opaque` and `pipe_pixel` for one cycle mid-frame. Required: at the next tick `state=10` and `bird_y` is unchanged.
  - The same overlap with `bright=0`. Required: no death.
- **Score:**
  - Preload 0x0999 via pulses, then one more `pipe_pass`. Required: 0x1000.
  - At 0x9999, one more pulse. Required: holds 0x9999.
  - `pipe_pass` in IDLE. Required: no change.
